// File: rtl/mastermind_solver.sv
// Mastermind codebreaker: proposes the smallest code above the last guess that is consistent
// with every stored (guess, red, white) entry. Define SOLVER_STATS_EN to build the SEARCH cycle counter.
module mastermind_solver #(
  parameter logic [11:0] FIRST_GUESS = 12'h009,
  parameter int          MAX_GUESSES = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  output logic [11:0] guess,
  output logic        guess_valid,
  input  logic        guess_ready,
  input  logic        fb_valid,
  output logic        fb_ready,
  input  logic [2:0]  fb_red,
  input  logic [2:0]  fb_white,
  output logic        busy,
  output logic        solved,
  output logic        fail,
  output logic [3:0]  num_guesses,
  output logic [15:0] search_cycles
);

  typedef enum logic [2:0] {S_IDLE, S_PRESENT, S_WAIT_FB, S_SEARCH, S_SOLVED, S_FAIL} state_t;

  state_t      state, state_nxt;
  logic [11:0] cand;
  logic [3:0]  idx, count;
  logic [11:0] hist_guess [0:15];
  logic [2:0]  hist_red   [0:15];
  logic [2:0]  hist_white [0:15];
  logic [5:0]  cand_score;
  logic        cand_match, last_entry, start_ok;

  // Returns {red, white} of code a scored against code b.
  function automatic logic [5:0] score(input logic [11:0] a, input logic [11:0] b);
    logic [2:0] red, tot, ca, cb;
    red = 3'd0;
    tot = 3'd0;
    for (int i = 0; i < 4; i++)
      if (a[3*i +: 3] == b[3*i +: 3]) red = red + 3'd1;
    for (int c = 0; c < 8; c++) begin
      ca = 3'd0;
      cb = 3'd0;
      for (int i = 0; i < 4; i++) begin
        if (a[3*i +: 3] == 3'(c)) ca = ca + 3'd1;
        if (b[3*i +: 3] == 3'(c)) cb = cb + 3'd1;
      end
      tot = tot + ((ca < cb) ? ca : cb);
    end
    return {red, 3'(tot - red)};
  endfunction

  always_comb begin
    cand_score = score(cand, hist_guess[idx]);
    cand_match = (cand_score == {hist_red[idx], hist_white[idx]});
    last_entry = (idx == count - 4'd1);
    start_ok   = start && (state == S_IDLE || state == S_SOLVED || state == S_FAIL);
  end

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_SOLVED, S_FAIL: if (start) state_nxt = S_PRESENT;
      S_PRESENT:                if (guess_ready) state_nxt = S_WAIT_FB;
      S_WAIT_FB:
        if (fb_valid) begin
          if (fb_red == 3'd4)                          state_nxt = S_SOLVED;
          else if (count == 4'(MAX_GUESSES - 1))       state_nxt = S_FAIL;
          else if (guess == 12'hFFF)                   state_nxt = S_FAIL;
          else                                         state_nxt = S_SEARCH;
        end
      S_SEARCH:
        if (!cand_match) begin
          if (cand == 12'hFFF) state_nxt = S_FAIL;
        end else if (last_entry) begin
          state_nxt = S_PRESENT;
        end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    guess_valid = 1'b0;
    fb_ready    = 1'b0;
    busy        = 1'b0;
    solved      = 1'b0;
    fail        = 1'b0;
    case (state)
      S_PRESENT: begin guess_valid = 1'b1; busy = 1'b1; end
      S_WAIT_FB: begin fb_ready = 1'b1; busy = 1'b1; end
      S_SEARCH:  busy = 1'b1;
      S_SOLVED:  solved = 1'b1;
      S_FAIL:    fail = 1'b1;
      default:   ;
    endcase
  end

  // Control registers: cleared by reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      guess       <= 12'd0;
      count       <= 4'd0;
      num_guesses <= 4'd0;
      idx         <= 4'd0;
    end else begin
      case (state)
        S_IDLE, S_SOLVED, S_FAIL:
          if (start) begin
            guess       <= FIRST_GUESS;
            count       <= 4'd0;
            num_guesses <= 4'd0;
          end
        S_WAIT_FB:
          if (fb_valid) begin
            num_guesses <= num_guesses + 4'd1;
            idx         <= 4'd0;
            if (fb_red != 3'd4) count <= count + 4'd1;
          end
        S_SEARCH:
          if (!cand_match)     idx   <= 4'd0;
          else if (last_entry) guess <= cand;
          else                 idx   <= idx + 4'd1;
        default: ;
      endcase
    end
  end

  // Data registers: history and candidate carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_WAIT_FB && fb_valid && fb_red != 3'd4) begin
      hist_guess[count] <= guess;
      hist_red[count]   <= fb_red;
      hist_white[count] <= fb_white;
      cand              <= guess + 12'd1;
    end else if (state == S_SEARCH && !cand_match) begin
      cand <= cand + 12'd1;
    end
  end

`ifdef SOLVER_STATS_EN
  logic [15:0] stat_cnt;
  always_ff @(posedge clk) begin
    if (!resetn)                                      stat_cnt <= 16'd0;
    else if (start_ok)                                stat_cnt <= 16'd0;
    else if (state == S_SEARCH && stat_cnt != 16'hFFFF) stat_cnt <= stat_cnt + 16'd1;
  end
  assign search_cycles = stat_cnt;
`else
  assign search_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_mastermind_solver.sv
// Directed bench for mastermind_solver: opening win, forced search, backpressure,
// reset abort, inconsistent feedback, full solve of 0x7A3, and history exhaustion.
module tb_mastermind_solver;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0, guess_ready = 1'b0, fb_valid = 1'b0;
  logic [2:0]  fb_red = 3'd0, fb_white = 3'd0;
  logic [11:0] guess;
  logic        guess_valid, fb_ready, busy, solved, fail;
  logic [3:0]  num_guesses;
  logic [15:0] search_cycles;

  logic        start2 = 1'b0, gr2 = 1'b0, fbv2 = 1'b0;
  logic [2:0]  red2 = 3'd0, white2 = 3'd0;
  logic [11:0] g2;
  logic        gv2, fbr2, busy2, solved2, fail2;
  logic [3:0]  num2;
  logic [15:0] sc2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mastermind_solver u_dut (
    .clk(clk), .resetn(resetn), .start(start), .guess(guess), .guess_valid(guess_valid),
    .guess_ready(guess_ready), .fb_valid(fb_valid), .fb_ready(fb_ready), .fb_red(fb_red),
    .fb_white(fb_white), .busy(busy), .solved(solved), .fail(fail),
    .num_guesses(num_guesses), .search_cycles(search_cycles));

  mastermind_solver #(.MAX_GUESSES(2)) u_dut2 (
    .clk(clk), .resetn(resetn), .start(start2), .guess(g2), .guess_valid(gv2),
    .guess_ready(gr2), .fb_valid(fbv2), .fb_ready(fbr2), .fb_red(red2),
    .fb_white(white2), .busy(busy2), .solved(solved2), .fail(fail2),
    .num_guesses(num2), .search_cycles(sc2));

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] mm_score(input logic [11:0] a, input logic [11:0] b);
    int r, m;
    int na [8];
    int nb [8];
    r = 0;
    m = 0;
    for (int c = 0; c < 8; c++) begin na[c] = 0; nb[c] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (a[3*i +: 3] == b[3*i +: 3]) r++;
      na[a[3*i +: 3]]++;
      nb[b[3*i +: 3]]++;
    end
    for (int c = 0; c < 8; c++) m += (na[c] < nb[c]) ? na[c] : nb[c];
    return {3'(r), 3'(m - r)};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic accept_guess();
    guess_ready = 1'b1;
    @(negedge clk);
    guess_ready = 1'b0;
  endtask

  task automatic give_fb(input logic [2:0] r, input logic [2:0] w);
    int k;
    k = 0;
    while (!fb_ready && k < 20) begin @(negedge clk); k++; end
    if (k >= 20) check_vec("fb_ready_timeout", 32'd0, 32'd1);
    fb_red = r;
    fb_white = w;
    fb_valid = 1'b1;
    @(negedge clk);
    fb_valid = 1'b0;
  endtask

  task automatic wait_event(input int limit, output int waited);
    waited = 0;
    while (!(guess_valid || solved || fail) && waited < limit) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= limit) check_vec("wait_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int w;
    logic [11:0] g, last;
    logic [5:0]  sc;
    logic [11:0] hg [16];
    logic [5:0]  hs [16];
    int nh;

    @(negedge clk);
    @(negedge clk);
    check_vec("rst_guess", 32'(guess), 32'h0);
    check_vec("rst_ctrl", 32'({guess_valid, fb_ready, busy, solved, fail}), 32'h0);
    check_vec("rst_num", 32'(num_guesses), 32'h0);
    check_vec("rst_stats", 32'(search_cycles), 32'h0);
    resetn = 1'b1;
    @(negedge clk);

    // Opening guess, backpressure, stray feedback, then immediate win.
    pulse_start();
    check_vec("first_valid", 32'(guess_valid), 32'h1);
    check_vec("first_guess", 32'(guess), 32'h009);
    check_vec("first_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      fb_valid = (i == 2);
      fb_red   = 3'd4;
      @(negedge clk);
      check_vec("bp_valid", 32'(guess_valid), 32'h1);
      check_vec("bp_guess", 32'(guess), 32'h009);
    end
    fb_valid = 1'b0;
    check_vec("stray_fb_num", 32'(num_guesses), 32'h0);
    accept_guess();
    check_vec("wait_fb_ready", 32'({fb_ready, guess_valid}), 32'h2);
    give_fb(3'd4, 3'd0);
    check_vec("win_solved", 32'({solved, busy, guess_valid}), 32'h4);
    check_vec("win_num", 32'(num_guesses), 32'h1);
    check_vec("win_guess", 32'(guess), 32'h009);

    // No shared colours forces a scan up to all-twos.
    pulse_start();
    check_vec("restart_clear", 32'({solved, num_guesses}), 32'h0);
    accept_guess();
    give_fb(3'd0, 3'd0);
    wait_event(6000, w);
    check_vec("g2_value", 32'(guess), 32'h492);
    check_vec("g2_latency", 32'(w), 32'h489);
`ifdef SOLVER_STATS_EN
    check_vec("g2_stats", 32'(search_cycles), 32'h489);
`else
    check_vec("g2_stats_off", 32'(search_cycles), 32'h0);
`endif

    // Reset during SEARCH aborts.
    accept_guess();
    give_fb(3'd0, 3'd0);
    repeat (3) @(negedge clk);
    check_vec("mid_search_busy", 32'({busy, guess_valid}), 32'h2);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    check_vec("abort_guess", 32'(guess), 32'h0);
    check_vec("abort_ctrl", 32'({guess_valid, fb_ready, busy, solved, fail}), 32'h0);
    check_vec("abort_num", 32'({num_guesses, search_cycles}), 32'h0);
    @(negedge clk);
    check_vec("abort_idle", 32'(busy), 32'h0);
    pulse_start();
    check_vec("reissue_guess", 32'({guess_valid, guess}), 32'h1009);

    // Impossible feedback: scan exhausts without wrap.
    accept_guess();
    give_fb(3'd3, 3'd1);
    wait_event(6000, w);
    check_vec("imp_fail", 32'({fail, solved, busy, guess_valid}), 32'h8);
    check_vec("imp_num", 32'(num_guesses), 32'h1);

    // Full solve of 0x7A3 against the bench scorer.
    pulse_start();
    nh = 0;
    last = 12'h0;
    for (int t = 0; t < 10; t++) begin
      wait_event(40000, w);
      if (!guess_valid) break;
      g = guess;
      if (nh > 0) check_vec("increasing", 32'(g > last), 32'h1);
      for (int j = 0; j < nh; j++) check_vec("consistent", 32'(mm_score(g, hg[j])), 32'(hs[j]));
      sc = mm_score(g, 12'h7A3);
      accept_guess();
      give_fb(sc[5:3], sc[2:0]);
      hg[nh] = g;
      hs[nh] = sc;
      nh++;
      last = g;
      if (sc[5:3] == 3'd4) break;
    end
    check_vec("solve_state", 32'({solved, fail, busy}), 32'h4);
    check_vec("solve_guess", 32'(guess), 32'h7A3);
    check_vec("solve_within8", 32'(num_guesses <= 4'd8), 32'h1);
    check_vec("solve_num", 32'(num_guesses), 32'(nh));

    // History depth 2 exhausted by two non-winning feedbacks.
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    check_vec("d2_first", 32'({gv2, g2}), 32'h1009);
    gr2 = 1'b1;
    @(negedge clk);
    gr2 = 1'b0;
    fbv2 = 1'b1;
    @(negedge clk);
    fbv2 = 1'b0;
    w = 0;
    while (!gv2 && w < 6000) begin @(negedge clk); w++; end
    check_vec("d2_second", 32'({gv2, g2}), 32'h1492);
    gr2 = 1'b1;
    @(negedge clk);
    gr2 = 1'b0;
    fbv2 = 1'b1;
    @(negedge clk);
    fbv2 = 1'b0;
    check_vec("d2_fail", 32'({fail2, solved2, busy2}), 32'h4);
    check_vec("d2_num", 32'(num2), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
